// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-stall FSM, branch flush and load-use interlock.
// Optional macro STALL_COUNT_EN adds a saturating 32-bit stall_cnt output.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_Rn,
    input  logic [4:0]  id_Rm,
    input  logic        id_uses_Rm,
    input  logic        ex_MemRead,
    input  logic [4:0]  ex_Rd,
    input  logic        br_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        memwb_bubble,
    output logic [1:0]  state,
    output logic        mem_err
`ifdef STALL_COUNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        BR_FLUSH = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic                br_pend_reg, br_pend_next;
    logic                mem_err_reg, mem_err_next;

    // Load-use detection: one comparator per ID source operand.
    logic [4:0] src_reg [2];
    logic [1:0] src_used;
    logic [1:0] src_match;

    assign src_reg[0]  = id_Rn;
    assign src_reg[1]  = id_Rm;
    assign src_used[0] = 1'b1;
    assign src_used[1] = id_uses_Rm;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
            assign src_match[gi] = src_used[gi] && (ex_Rd == src_reg[gi]);
        end
    endgenerate

    logic load_use;
    logic mem_stall;

    // X31 is the zero register, so a load targeting it never creates a dependency.
    assign load_use  = ex_MemRead && (ex_Rd != 5'd31) && (|src_match);
    assign mem_stall = mem_req && !mem_ready;

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        br_pend_next  = br_pend_reg;
        mem_err_next  = mem_err_reg;
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        exmem_en      = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        memwb_bubble  = 1'b0;

        if (reset) begin
            case (state_reg)
                RUN: begin
                    if (mem_stall) begin
                        pc_en         = 1'b0;
                        ifid_en       = 1'b0;
                        idex_en       = 1'b0;
                        exmem_en      = 1'b0;
                        memwb_bubble  = 1'b1;
                        br_pend_next  = br_pend_reg | br_taken;
                        wait_cnt_next = WAIT_ONE;
                        state_next    = MEM_WAIT;
                    end else if (br_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end

                MEM_WAIT: begin
                    // A branch seen in the release cycle is still deferred to BR_FLUSH.
                    br_pend_next = br_pend_reg | br_taken;
                    if (mem_ready || (wait_cnt_reg >= WAIT_LIMIT)) begin
                        if (!mem_ready) begin
                            mem_err_next = 1'b1;
                        end
                        wait_cnt_next = '0;
                        state_next    = (br_pend_reg | br_taken) ? BR_FLUSH : RUN;
                    end else begin
                        pc_en         = 1'b0;
                        ifid_en       = 1'b0;
                        idex_en       = 1'b0;
                        exmem_en      = 1'b0;
                        memwb_bubble  = 1'b1;
                        wait_cnt_next = wait_cnt_reg + WAIT_ONE;
                    end
                end

                BR_FLUSH: begin
                    ifid_flush   = 1'b1;
                    idex_bubble  = 1'b1;
                    br_pend_next = 1'b0;
                    state_next   = RUN;
                end

                default: begin
                    wait_cnt_next = '0;
                    state_next    = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
            br_pend_reg  <= 1'b0;
            mem_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            br_pend_reg  <= br_pend_next;
            mem_err_reg  <= mem_err_next;
        end
    end

    assign state   = state_reg;
    assign mem_err = mem_err_reg;

`ifdef STALL_COUNT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_reg <= '0;
        end else if (!pc_en && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 16, maximum cycles spent in MEM_WAIT before abort.
REQ-002 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-low reset.
REQ-004 Port: id_Rn, id_Rm  in  5 each  source registers of the instruction in ID.
REQ-005 Port: id_uses_Rm  in  1  ID instruction reads id_Rm.
REQ-006 Port: ex_MemRead  in  1  instruction in EX is a load.
REQ-007 Port: ex_Rd  in  5  destination register of the instruction in EX.
REQ-008 Port: br_taken  in  1  branch resolved taken this cycle.
REQ-009 Port: mem_req  in  1  EX/MEM stage holds a load or store.
REQ-010 Port: mem_ready  in  1  data memory completes the current access.
REQ-011 Port: pc_en, ifid_en, idex_en, exmem_en  out  1 each  register write enables.
REQ-012 Port: ifid_flush, idex_bubble, memwb_bubble  out  1 each  insert NOP into the named register.
REQ-013 Port: state  out  2  encoding: RUN=0, MEM_WAIT=1, BR_FLUSH=2.
REQ-014 Port: mem_err  out  1  sticky timeout flag.

Function
REQ-015 The FSM SHALL have states RUN, MEM_WAIT and BR_FLUSH, held in a registered state variable; all other outputs are combinational from state, registers and inputs.
REQ-016 In RUN, mem_req=1 with mem_ready=0 SHALL hold all enables at 0 and memwb_bubble at 1 this cycle, then enter MEM_WAIT with wait counter = 1.
REQ-017 In MEM_WAIT, the block SHALL keep all enables at 0 and memwb_bubble at 1, and increment the wait counter each cycle.
REQ-018 In MEM_WAIT, mem_ready=1 SHALL raise all enables to 1 and clear memwb_bubble in the same cycle; next state is BR_FLUSH if br_pend=1, else RUN.
REQ-019 If the wait counter reaches MEM_TIMEOUT while mem_ready=0, the block SHALL set mem_err, release enables as in REQ-018 and leave MEM_WAIT.
REQ-020 A load-use hazard is: ex_MemRead=1, ex_Rd!=31, and (ex_Rd==id_Rn or (id_uses_Rm=1 and ex_Rd==id_Rm)).
REQ-021 In RUN with no memory stall, a load-use hazard SHALL drive pc_en=0, ifid_en=0 and idex_bubble=1, with exmem_en=1, for exactly the hazard cycle.
REQ-022 In RUN with no memory stall, br_taken=1 SHALL drive ifid_flush=1 and idex_bubble=1 with all enables at 1; this overrides the load-use stall.
REQ-023 br_taken=1 arriving during a memory stall (REQ-016/017) SHALL set br_pend and SHALL NOT flush that cycle.
REQ-024 BR_FLUSH SHALL last one cycle: ifid_flush=1, idex_bubble=1, all enables 1, br_pend cleared; next state RUN. It has no stall checks.
REQ-025 Priority SHALL be memory stall > branch flush > load-use > normal; in normal operation all enables are 1 and all flush/bubble outputs are 0.
REQ-026 Register X31 SHALL never cause a hazard.
REQ-027 The wait counter SHALL be wide enough for MEM_TIMEOUT, reset to 0 and cleared on leaving MEM_WAIT.

Reset
REQ-028 When reset=0 at a rising edge, the block SHALL set state=RUN, wait counter=0, br_pend=0 and mem_err=0, including when reset arrives mid MEM_WAIT.
REQ-029 While reset=0, outputs SHALL read all enables 1 and all flush/bubble outputs 0.
REQ-030 mem_err SHALL be cleared only by reset.

Configuration
REQ-031 With STALL_COUNT_EN defined, the block SHALL add output stall_cnt (32-bit), incremented in every cycle with pc_en=0, saturating at all ones and reset to 0.
REQ-032 With STALL_COUNT_EN undefined, the port and its counter SHALL be absent, and behaviour SHALL otherwise be identical.

Verification
REQ-033 Scenario: ex_MemRead=1, ex_Rd=5, id_Rn=5 in RUN -> one cycle of pc_en=0, ifid_en=0, idex_bubble=1, then normal.
REQ-034 Scenario: ex_Rd=31 with ex_MemRead=1, id_Rn=31 -> no stall.
REQ-035 Scenario: mem_req=1, mem_ready low for 3 cycles then high -> all enables 0 for 3 cycles, 1 on the 4th; state 0->1->0.
REQ-036 Scenario: br_taken pulsed during MEM_WAIT, then mem_ready=1 -> next cycle state=2 with ifid_flush=1 and idex_bubble=1, then RUN.
REQ-037 Scenario: MEM_TIMEOUT=4, mem_ready held 0 -> mem_err=1 after 4 wait cycles and state returns to RUN; reset=0 clears mem_err.
REQ-038 Scenario: reset=0 asserted mid MEM_WAIT -> next cycle state=0, all enables 1; with STALL_COUNT_EN defined, stall_cnt=0.
